// File: rtl/hazard_forward_unit.sv
// Single hazard block for the 5-stage pipeline: operand forwarding, load-use bubbles,
// multi-cycle multiplier stall FSM and a saturating stall-cycle counter.
module hazard_forward_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_regwrite,
    input  logic                        ex_memread,
    input  logic                        ex_mul_start,
    input  logic [REG_AW-1:0]           mem_rd,
    input  logic                        mem_regwrite,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic                        wb_regwrite,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        flush_ex,
    output logic                        hold_ex,
    output logic                        mul_busy,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int unsigned MCW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam bit          MUL_EN   = (MUL_LAT > 1);
    localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_LAT - 1);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             mul_go;

    // Per-operand bypass select; EX/MEM beats MEM/WB when both match.
    always_comb begin
        fwd_sel = '0;
        if (!reset) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (mem_regwrite && (mem_rd != '0) &&
                    (mem_rd == ex_src[i*REG_AW +: REG_AW])) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end else if (wb_regwrite && (wb_rd != '0) &&
                             (wb_rd == ex_src[i*REG_AW +: REG_AW])) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    // Load in EX whose result a used decode operand needs next cycle.
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd)) begin
                lu = 1'b1;
            end
        end
        lu = lu && ex_memread && ex_regwrite && (ex_rd != '0) && id_valid;
    end

    assign mul_go = MUL_EN && ex_mul_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            S_IDLE: begin
                if (mul_go) begin
                    state_d = S_MUL_BUSY;
                    mcnt_d  = MUL_LOAD;
                end
            end
            S_MUL_BUSY: begin
                mcnt_d = mcnt_q - MCW'(1);
                if (mcnt_q == MCW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A multiply start in IDLE pre-empts a coincident load-use bubble.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_ex = 1'b0;
        hold_ex  = 1'b0;
        mul_busy = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (!mul_go && lu) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                S_MUL_BUSY: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    hold_ex  = 1'b1;
                    mul_busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_if && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three parameterisations share one stimulus stream and
// are checked each cycle against a cycle-count model plus hand-computed expectations.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [9:0]  ex_src;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_mul_start;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;

    logic [3:0]  f0, f1, f2;
    logic        sif0, sid0, fex0, hex0, mb0;
    logic        sif1, sid1, fex1, hex1, mb1;
    logic        sif2, sid2, fex2, hex2, mb2;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    int checks = 0;
    int errors = 0;

    int m_busy[3] = '{0, 0, 0};
    int m_cnt[3]  = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mul_start(ex_mul_start),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_sel(f0), .stall_if(sif0), .stall_id(sid0), .flush_ex(fex0), .hold_ex(hex0),
        .mul_busy(mb0), .stall_cnt(sc0));

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mul_start(ex_mul_start),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_sel(f1), .stall_if(sif1), .stall_id(sid1), .flush_ex(fex1), .hold_ex(hex1),
        .mul_busy(mb1), .stall_cnt(sc1));

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(4), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mul_start(ex_mul_start),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_sel(f2), .stall_if(sif2), .stall_id(sid2), .flush_ex(fex2), .hold_ex(hex2),
        .mul_busy(mb2), .stall_cnt(sc2));

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [3:0] m_fwd();
        logic [3:0] r;
        logic [4:0] s;
        r = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            s = ex_src[i*5 +: 5];
            if (mem_regwrite && mem_rd != 5'd0 && mem_rd == s)    r[2*i +: 2] = 2'b10;
            else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == s) r[2*i +: 2] = 2'b01;
        end
        return reset ? 4'b0000 : r;
    endfunction

    function automatic bit m_lu();
        bit hit;
        hit = (id_src_used[0] && id_src[4:0] == ex_rd) || (id_src_used[1] && id_src[9:5] == ex_rd);
        return ex_memread && ex_regwrite && ex_rd != 5'd0 && id_valid && hit;
    endfunction

    function automatic bit m_start(input int k);
        return ex_mul_start && lat_of(k) > 1;
    endfunction

    function automatic bit m_stall(input int k);
        if (reset) return 1'b0;
        if (m_busy[k] > 0) return 1'b1;
        return m_lu() && !m_start(k);
    endfunction

    function automatic bit m_flush(input int k);
        return !reset && m_busy[k] == 0 && m_lu() && !m_start(k);
    endfunction

    function automatic bit m_mbusy(input int k);
        return !reset && m_busy[k] > 0;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic [3:0] f, input logic sif, input logic sid,
                       input logic fex, input logic hx, input logic mb, input logic [15:0] sc);
        chk("fwd_sel", k, 32'(f), 32'(m_fwd()));
        chk("stall_if", k, 32'(sif), 32'(m_stall(k)));
        chk("stall_id", k, 32'(sid), 32'(m_stall(k)));
        chk("flush_ex", k, 32'(fex), 32'(m_flush(k)));
        chk("hold_ex", k, 32'(hx), 32'(m_mbusy(k)));
        chk("mul_busy", k, 32'(mb), 32'(m_mbusy(k)));
        chk("stall_cnt", k, 32'(sc), reset ? 32'd0 : 32'(m_cnt[k]));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        cmp(0, f0, sif0, sid0, fex0, hex0, mb0, sc0);
        cmp(1, f1, sif1, sid1, fex1, hex1, mb1, sc1);
        cmp(2, f2, sif2, sid2, fex2, hex2, mb2, {12'd0, sc2});
    end

    // Model advance: remaining busy cycles and saturating stall count.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_busy[k] = 0;
                m_cnt[k]  = 0;
            end else begin
                if (m_stall(k) && m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
                if (m_busy[k] > 0)    m_busy[k] = m_busy[k] - 1;
                else if (m_start(k)) m_busy[k] = lat_of(k) - 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        id_valid = 0; id_src = '0; id_src_used = '0; ex_src = '0; ex_rd = '0;
        ex_regwrite = 0; ex_memread = 0; ex_mul_start = 0;
        mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
    endtask

    task automatic set_lu(input logic [1:0] used);
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_valid = 1;
        id_src = {5'd0, 5'd5}; id_src_used = used;
    endtask

    initial begin
        clear();
        reset = 1;
        mem_regwrite = 1; mem_rd = 5'd8; ex_src = {5'd9, 5'd8};
        @(negedge clk);
        chk("rst_fwd_gated", 0, 32'(f0), 32'd0);
        chk("rst_cnt", 0, 32'(sc0), 32'd0);
        cyc();
        cyc(); reset = 0;
        wb_regwrite = 1; wb_rd = 5'd8;
        @(negedge clk);
        chk("fwd_exmem_prio", 0, 32'(f0), 32'h2);
        cyc(); wb_rd = 5'd9;
        @(negedge clk);
        chk("fwd_both_srcs", 0, 32'(f0), 32'h6);
        cyc(); mem_rd = 5'd0; wb_rd = 5'd0; ex_src = '0;
        @(negedge clk);
        chk("fwd_rd_zero", 0, 32'(f0), 32'h0);
        cyc(); mem_rd = 5'd9; wb_rd = 5'd9; ex_src = {5'd9, 5'd9};
        @(negedge clk);
        chk("fwd_both_exmem", 0, 32'(f0), 32'hA);

        cyc(); clear(); set_lu(2'b01);
        @(negedge clk);
        chk("lu_stall", 0, 32'(sif0), 32'd1);
        chk("lu_flush", 0, 32'(fex0), 32'd1);
        cyc(); clear();
        @(negedge clk);
        chk("lu_one_cycle", 0, 32'(sif0), 32'd0);
        chk("lu_cnt", 0, 32'(sc0), 32'd1);
        cyc(); set_lu(2'b00);
        @(negedge clk);
        chk("lu_unused_src", 0, 32'(sif0), 32'd0);
        cyc(); clear();

        cyc(); ex_mul_start = 1;
        @(negedge clk);
        chk("mul_start_idle", 0, 32'(mb0), 32'd0);
        cyc(); clear();
        @(negedge clk);
        chk("mul_busy1", 0, 32'(mb0), 32'd1);
        chk("mul_hold1", 0, 32'(hex0), 32'd1);
        chk("mul1_nostall", 1, 32'(sif1), 32'd0);
        cyc();
        @(negedge clk);
        chk("mul_busy2", 0, 32'(mb0), 32'd1);
        cyc();
        @(negedge clk);
        chk("mul_done", 0, 32'(mb0), 32'd0);
        chk("mul_cnt", 0, 32'(sc0), 32'd3);
        chk("mul_lat4_busy3", 2, 32'(mb2), 32'd1);
        chk("mul_lat1_cnt", 1, 32'(sc1), 32'd1);
        cyc();
        @(negedge clk);
        chk("mul_lat4_cnt", 2, 32'(sc2), 32'd4);

        cyc(); set_lu(2'b01); ex_mul_start = 1;
        @(negedge clk);
        chk("mul_over_lu_stall", 0, 32'(sif0), 32'd0);
        chk("mul_over_lu_flush", 0, 32'(fex0), 32'd0);
        chk("lat1_lu_flush", 1, 32'(fex1), 32'd1);
        cyc(); clear();
        @(negedge clk);
        chk("mul_over_lu_busy", 0, 32'(mb0), 32'd1);
        chk("mul_over_lu_noflush", 0, 32'(fex0), 32'd0);
        repeat (4) cyc();

        ex_mul_start = 1;
        cyc(); clear();
        cyc(); reset = 1;
        @(negedge clk);
        chk("rst_mid_busy", 2, 32'(mb2), 32'd0);
        chk("rst_mid_stall", 2, 32'(sif2), 32'd0);
        chk("rst_mid_cnt", 2, 32'(sc2), 32'd0);
        cyc();
        cyc(); reset = 0;
        @(negedge clk);
        chk("post_rst_busy", 2, 32'(mb2), 32'd0);
        chk("post_rst_stall", 2, 32'(sif2), 32'd0);
        chk("post_rst_cnt", 2, 32'(sc2), 32'd0);

        cyc(); set_lu(2'b01);
        repeat (19) cyc();
        cyc(); clear();
        @(negedge clk);
        chk("sat_cnt4", 2, 32'(sc2), 32'd15);
        chk("cnt16_20", 0, 32'(sc0), 32'd20);
        repeat (3) cyc();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
